pe_sequencer: RTL and testbench
===============================

// Module: pe_sequencer
// PURPOSE
//  Parametrised phase sequencer for a complex-data PE: runs LOAD -> (COMPUTE -> TRANSMIT -> SHIFT)*N -> COMPUTE -> OUTPUT.
//  Generates phase valids, instruction-ROM address/valid, delayed DMEM shift-read valid, TX forwarding and result output.
//  Additions: runtime iteration count, output backpressure, abort, done pulse. Sits between the PE datapath (DMEM/ALU) and the array fabric.
// PARAMETERS
//  DATA_WIDTH  16  width of one real component; complex word is 2*DATA_WIDTH
//  IM_ADDR_W   8   instruction ROM address width (INST_NUM <= 2**IM_ADDR_W)
//  LOAD_NUM    32  cycles spent in LOAD
//  INST_NUM    64  instructions (cycles) per COMPUTE pass
//  TX_NUM      4   words forwarded per TRANSMIT pass
//  REG_NUM     16  cycles per SHIFT pass
//  OUT_NUM     4   result words handshaked in OUTPUT
//  ITER_W      7   width of iteration count/index
//  DMEM_LAT    3   shift_v -> shift_rd_v delay (cycles, >=1)
// PORTS
//  clk         in   1            clock, all logic posedge
//  rst         in   1            synchronous, active-high reset
//  iter_num    in   ITER_W       COMPUTE passes per job; sampled on IDLE->LOAD
//  din_pe_v    in   1            load-data valid; starts a job from IDLE
//  abort       in   1            synchronous job cancel
//  alu_d       in   2*DATA_WIDTH ALU result
//  dout_pe_rdy in   1            downstream ready for dout_pe
//  busy        out  1            state != IDLE
//  done        out  1            1-cycle pulse at normal job completion
//  iter_idx    out  ITER_W       current COMPUTE pass index (0-based)
//  load_v/cmpt_v/tx_v/shift_v out 1 each  phase valids (state decode)
//  inst_addr   out  IM_ADDR_W    instruction ROM address
//  inst_v      out  1            cmpt_v delayed 1 cycle (ROM data valid)
//  shift_rd_v  out  1            shift_v delayed DMEM_LAT cycles
//  dout_tx_v   out  1            = tx_v
//  dout_tx     out  2*DATA_WIDTH alu_r when tx_v else 0
//  dout_pe_v   out  1            high throughout OUTPUT
//  dout_pe     out  2*DATA_WIDTH alu_r when dout_pe_v else 0
// BEHAVIOUR
//  States IDLE, LOAD, COMPUTE, TRANSMIT, SHIFT, OUTPUT; phase valids/dout_pe_v are pure decodes of the state register.
//  Reset: state=IDLE; all counters, iter_idx, alu_r, delay lines = 0; every output 0.
//  IDLE: din_pe_v=1 & abort=0 -> LOAD; iter_tgt <= (iter_num==0) ? 1 : iter_num.
//  LOAD: exactly LOAD_NUM cycles, independent of din_pe_v, then COMPUTE.
//  COMPUTE: INST_NUM cycles; inst_addr = cycle count 0..INST_NUM-1, 0 in all other states.
//   Last cycle: iter_idx==iter_tgt-1 -> OUTPUT, else -> TRANSMIT.
//  TRANSMIT: TX_NUM cycles -> SHIFT. SHIFT: REG_NUM cycles -> COMPUTE, iter_idx += 1 on that transition.
//  OUTPUT: one beat per cycle with dout_pe_v & dout_pe_rdy; after OUT_NUM beats -> IDLE, done=1 in first IDLE cycle.
//   alu_r <= alu_d every cycle except when dout_pe_v & !dout_pe_rdy (held stable while stalled).
//  iter_idx cleared on entering LOAD; holds its final value in IDLE until the next job.
//  abort=1 in any non-IDLE state: next cycle IDLE, all counters 0, no done; delay lines drain naturally.
//  abort and din_pe_v together in IDLE: abort wins, stay IDLE. rst overrides abort and clears delay lines.
//  Counters sized $clog2 of their limit (min 1 bit); no wrap-around: each counter resets to 0 on its terminal count.
//  Job length with no stall: 1 + LOAD_NUM + N*INST_NUM + (N-1)*(TX_NUM+REG_NUM) + OUT_NUM cycles from din_pe_v to done (N=iter_tgt).
// TESTING
//  1) Defaults, iter_num=4, rdy=1: din_pe_v pulse -> 32 load, 4x64 cmpt, 3x(4 tx+16 shift), 4 out; done 1 cycle after last beat.
//  2) iter_num=1: LOAD -> COMPUTE -> OUTPUT directly; tx_v/shift_v never assert; iter_num=0 behaves identically.
//  3) OUTPUT with rdy low for 5 cycles on beat 2: dout_pe held constant, beat count frozen, 4 beats still delivered.
//  4) abort in SHIFT of pass 1: IDLE next cycle, no done, shift_rd_v finishes its DMEM_LAT tail then 0; new job starts cleanly.
//  5) Check inst_addr 0..63 per pass, inst_v = cmpt_v>>1, shift_rd_v = shift_v>>3, dout_tx = alu_d delayed 1 during tx_v.
//  6) rst asserted mid-COMPUTE: all outputs 0 next cycle; abort+din_pe_v same cycle in IDLE -> stays IDLE.

Source files
------------

// File: rtl/pe_sequencer.sv
// pe_sequencer: phase sequencer for a complex-data PE.
// Runs LOAD -> (COMPUTE -> TRANSMIT -> SHIFT)*N -> COMPUTE -> OUTPUT,
// driving phase valids, instruction-ROM addressing, the delayed DMEM
// shift-read valid, TX forwarding and the handshaked result output.
module pe_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int IM_ADDR_W  = 8,
  parameter int LOAD_NUM   = 32,
  parameter int INST_NUM   = 64,
  parameter int TX_NUM     = 4,
  parameter int REG_NUM    = 16,
  parameter int OUT_NUM    = 4,
  parameter int ITER_W     = 7,
  parameter int DMEM_LAT   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ITER_W-1:0]       iter_num,
  input  logic                    din_pe_v,
  input  logic                    abort,
  input  logic [2*DATA_WIDTH-1:0] alu_d,
  input  logic                    dout_pe_rdy,
  output logic                    busy,
  output logic                    done,
  output logic [ITER_W-1:0]       iter_idx,
  output logic                    load_v,
  output logic                    cmpt_v,
  output logic                    tx_v,
  output logic                    shift_v,
  output logic [IM_ADDR_W-1:0]    inst_addr,
  output logic                    inst_v,
  output logic                    shift_rd_v,
  output logic                    dout_tx_v,
  output logic [2*DATA_WIDTH-1:0] dout_tx,
  output logic                    dout_pe_v,
  output logic [2*DATA_WIDTH-1:0] dout_pe
);

  // One phase counter serves every state; it is sized for the longest phase
  // and always returns to 0 on the terminal count of the current phase.
  localparam int MAX_A   = (LOAD_NUM > INST_NUM) ? LOAD_NUM : INST_NUM;
  localparam int MAX_B   = (TX_NUM > REG_NUM) ? TX_NUM : REG_NUM;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_MAX = (MAX_C > OUT_NUM) ? MAX_C : OUT_NUM;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_NUM - 1);
  localparam logic [CNT_W-1:0] INST_LAST  = CNT_W'(INST_NUM - 1);
  localparam logic [CNT_W-1:0] TX_LAST    = CNT_W'(TX_NUM - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(REG_NUM - 1);
  localparam logic [CNT_W-1:0] OUT_LAST   = CNT_W'(OUT_NUM - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, COMPUTE, TRANSMIT, SHIFT, OUTPUT
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_term;
  logic                    cnt_last;
  logic [ITER_W-1:0]       iter_tgt;
  logic [DMEM_LAT-1:0]     shift_pipe;
  logic [2*DATA_WIDTH-1:0] alu_r;
  logic                    out_stall;

  // Terminal count of the phase currently running.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_term = '0;
    case (state)
      LOAD:     cnt_term = LOAD_LAST;
      COMPUTE:  cnt_term = INST_LAST;
      TRANSMIT: cnt_term = TX_LAST;
      SHIFT:    cnt_term = SHIFT_LAST;
      OUTPUT:   cnt_term = OUT_LAST;
      default:  cnt_term = '0;
    endcase
  end

  assign cnt_last  = (cnt == cnt_term);
  assign out_stall = dout_pe_v && !dout_pe_rdy;

  // Phase sequencing, iteration tracking and the completion pulse.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      iter_idx <= '0;
      iter_tgt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (din_pe_v && !abort) begin
              state    <= LOAD;
              cnt      <= '0;
              iter_idx <= '0;
              iter_tgt <= (iter_num == '0) ? ITER_W'(1) : iter_num;
            end
          end
          LOAD: begin
            if (cnt_last) begin
              cnt   <= '0;
              state <= COMPUTE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          COMPUTE: begin
            if (cnt_last) begin
              cnt   <= '0;
              state <= (iter_idx == iter_tgt - ITER_W'(1)) ? OUTPUT : TRANSMIT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          TRANSMIT: begin
            if (cnt_last) begin
              cnt   <= '0;
              state <= SHIFT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          SHIFT: begin
            if (cnt_last) begin
              cnt      <= '0;
              state    <= COMPUTE;
              iter_idx <= iter_idx + ITER_W'(1);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          OUTPUT: begin
            // Beats only advance on a completed handshake.
            if (dout_pe_rdy) begin
              if (cnt_last) begin
                cnt   <= '0;
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // ROM-data valid and DMEM read-valid delay lines; abort lets them drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_v     <= 1'b0;
      shift_pipe <= '0;
    end else begin
      inst_v     <= cmpt_v;
      shift_pipe <= (shift_pipe << 1) | DMEM_LAT'(shift_v);
    end
  end

  // ALU result capture; frozen while an output beat is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_r <= '0;
    end else if (!out_stall) begin
      alu_r <= alu_d;
    end
  end

  assign busy       = (state != IDLE);
  assign load_v     = (state == LOAD);
  assign cmpt_v     = (state == COMPUTE);
  assign tx_v       = (state == TRANSMIT);
  assign shift_v    = (state == SHIFT);
  assign dout_pe_v  = (state == OUTPUT);
  assign inst_addr  = cmpt_v ? IM_ADDR_W'(cnt) : '0;
  assign shift_rd_v = shift_pipe[DMEM_LAT-1];
  assign dout_tx_v  = tx_v;
  assign dout_tx    = tx_v ? alu_r : '0;
  assign dout_pe    = dout_pe_v ? alu_r : '0;

endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer: scoreboard bench for pe_sequencer. Each job start pushes
// the job's whole expected phase plan into a queue; a negedge monitor pops
// one entry per cycle (one per accepted beat in OUTPUT) and compares.
module tb_pe_sequencer;

  localparam int DW       = 16;
  localparam int IM_W     = 8;
  localparam int LOAD_NUM = 32;
  localparam int INST_NUM = 64;
  localparam int TX_NUM   = 4;
  localparam int REG_NUM  = 16;
  localparam int OUT_NUM  = 4;
  localparam int ITER_W   = 7;
  localparam int DMEM_LAT = 3;

  localparam int PH_LOAD  = 1;
  localparam int PH_CMPT  = 2;
  localparam int PH_TX    = 3;
  localparam int PH_SHIFT = 4;
  localparam int PH_OUT   = 5;

  typedef struct {
    int ph;
    int addr;
    int iter;
  } tok_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [ITER_W-1:0] iter_num;
  logic              din_pe_v;
  logic              abort;
  logic [2*DW-1:0]   alu_d;
  logic              dout_pe_rdy;
  logic              busy, done, load_v, cmpt_v, tx_v, shift_v;
  logic              inst_v, shift_rd_v, dout_tx_v, dout_pe_v;
  logic [ITER_W-1:0] iter_idx;
  logic [IM_W-1:0]   inst_addr;
  logic [2*DW-1:0]   dout_tx, dout_pe;

  pe_sequencer #(
    .DATA_WIDTH(DW), .IM_ADDR_W(IM_W), .LOAD_NUM(LOAD_NUM), .INST_NUM(INST_NUM),
    .TX_NUM(TX_NUM), .REG_NUM(REG_NUM), .OUT_NUM(OUT_NUM), .ITER_W(ITER_W),
    .DMEM_LAT(DMEM_LAT)
  ) dut (
    .clk(clk), .rst(rst), .iter_num(iter_num), .din_pe_v(din_pe_v),
    .abort(abort), .alu_d(alu_d), .dout_pe_rdy(dout_pe_rdy),
    .busy(busy), .done(done), .iter_idx(iter_idx), .load_v(load_v),
    .cmpt_v(cmpt_v), .tx_v(tx_v), .shift_v(shift_v), .inst_addr(inst_addr),
    .inst_v(inst_v), .shift_rd_v(shift_rd_v), .dout_tx_v(dout_tx_v),
    .dout_tx(dout_tx), .dout_pe_v(dout_pe_v), .dout_pe(dout_pe)
  );

  always #5 clk = ~clk;

  // Scoreboard and reference-model state.
  tok_t              exp_q[$];
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                job_start = 0;
  bit                rdy_rand = 1'b0;
  bit                rdy_force_en = 1'b0;
  bit                rdy_force_val = 1'b1;
  logic [2*DW-1:0]   alu_model = '0;
  bit                done_pend = 1'b0;
  int                iter_hold = 0;
  bit                iter_known = 1'b1;
  bit                cmpt_prev = 1'b0;
  bit [DMEM_LAT-1:0] sh_hist = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Expected per-cycle phase plan of one job (N COMPUTE passes).
  task automatic push_plan(input int n_in);
    int n;
    n = (n_in == 0) ? 1 : n_in;
    for (int i = 0; i < LOAD_NUM; i++) exp_q.push_back('{PH_LOAD, 0, 0});
    for (int p = 0; p < n; p++) begin
      for (int a = 0; a < INST_NUM; a++) exp_q.push_back('{PH_CMPT, a, p});
      if (p < n - 1) begin
        for (int i = 0; i < TX_NUM; i++)  exp_q.push_back('{PH_TX, 0, p});
        for (int i = 0; i < REG_NUM; i++) exp_q.push_back('{PH_SHIFT, 0, p});
      end
    end
    for (int i = 0; i < OUT_NUM; i++) exp_q.push_back('{PH_OUT, 0, n - 1});
  endtask

  // Monitor: compares the DUT against the front of the plan every cycle.
  task automatic monitor_cycle();
    tok_t t;
    bit   act, e_load, e_cmpt, e_tx, e_sh, e_out, new_done;
    act = (exp_q.size() > 0);
    t   = act ? exp_q[0] : '{0, 0, 0};
    e_load = act && t.ph == PH_LOAD;
    e_cmpt = act && t.ph == PH_CMPT;
    e_tx   = act && t.ph == PH_TX;
    e_sh   = act && t.ph == PH_SHIFT;
    e_out  = act && t.ph == PH_OUT;

    check("busy", busy, act);
    check("load_v", load_v, e_load);
    check("cmpt_v", cmpt_v, e_cmpt);
    check("tx_v", tx_v, e_tx);
    check("shift_v", shift_v, e_sh);
    check("dout_pe_v", dout_pe_v, e_out);
    check("dout_tx_v", dout_tx_v, e_tx);
    check("inst_addr", inst_addr, e_cmpt ? t.addr : 0);
    check("inst_v", inst_v, cmpt_prev);
    check("shift_rd_v", shift_rd_v, sh_hist[DMEM_LAT-1]);
    check("done", done, done_pend);
    check("dout_tx", dout_tx, e_tx ? alu_model : '0);
    check("dout_pe", dout_pe, e_out ? alu_model : '0);
    if (act) check("iter_idx", iter_idx, t.iter);
    else if (iter_known) check("iter_idx_idle", iter_idx, iter_hold);

    new_done = 1'b0;
    if (act) begin
      if (t.ph != PH_OUT || dout_pe_rdy) begin
        void'(exp_q.pop_front());
        if (t.ph == PH_OUT && exp_q.size() == 0) new_done = 1'b1;
      end
      iter_hold  = t.iter;
      iter_known = 1'b1;
    end
    cmpt_prev = e_cmpt;
    sh_hist   = {sh_hist[DMEM_LAT-2:0], e_sh};
    if (!(e_out && !dout_pe_rdy)) alu_model = alu_d;
    if (abort && act) begin
      exp_q.delete();
      new_done   = 1'b0;
      iter_known = 1'b0;
    end
    done_pend = new_done;
    if (rst) begin
      exp_q.delete();
      done_pend  = 1'b0;
      cmpt_prev  = 1'b0;
      sh_hist    = '0;
      alu_model  = '0;
      iter_hold  = 0;
      iter_known = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitor_cycle();
    end
  end

  // One clock of stimulus: fresh ALU data, ready per the current mode.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    alu_d = $urandom;
    if (rdy_force_en) dout_pe_rdy = rdy_force_val;
    else if (rdy_rand) dout_pe_rdy = ($urandom_range(0, 3) != 0);
    else dout_pe_rdy = 1'b1;
  endtask

  task automatic start_job(input int n);
    iter_num  = ITER_W'(n);
    din_pe_v  = 1'b1;
    job_start = cyc;
    tick();
    din_pe_v  = 1'b0;
    push_plan(n);
  endtask

  task automatic wait_done(input int n_in, input int extra, input bit check_len);
    int k, n;
    n = (n_in == 0) ? 1 : n_in;
    k = 0;
    while (!done && k < 3000) begin
      tick();
      k++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout t=%0t actual=no_done required=done", $time);
    end else if (check_len) begin
      check("job_len", cyc - job_start,
            1 + LOAD_NUM + n * INST_NUM + (n - 1) * (TX_NUM + REG_NUM) + OUT_NUM + extra);
    end
  endtask

  // Advance until the plan front matches (-1 = don't care).
  task automatic wait_tok(input int ph, input int addr, input int iter, input int qsz);
    int  k;
    bit  hit;
    k = 0;
    hit = 1'b0;
    while (!hit && k < 3000) begin
      if (exp_q.size() > 0)
        hit = exp_q[0].ph == ph && (addr < 0 || exp_q[0].addr == addr) &&
              (iter < 0 || exp_q[0].iter == iter) && (qsz < 0 || exp_q.size() == qsz);
      if (!hit) begin
        tick();
        k++;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_tok t=%0t actual=not_reached required=phase%0d", $time, ph);
    end
  endtask

  initial begin
    rst         = 1'b1;
    iter_num    = '0;
    din_pe_v    = 1'b0;
    abort       = 1'b0;
    alu_d       = '0;
    dout_pe_rdy = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Full four-pass job with continuous ready.
    start_job(4);
    wait_done(4, 0, 1'b1);
    repeat (3) tick();

    // Single pass: straight from COMPUTE to OUTPUT; zero behaves as one.
    start_job(1);
    wait_done(1, 0, 1'b1);
    tick();
    start_job(0);
    wait_done(0, 0, 1'b1);
    repeat (2) tick();

    // Stall on the second output beat for five cycles.
    start_job(2);
    wait_tok(PH_OUT, -1, -1, OUT_NUM - 1);
    rdy_force_en  = 1'b1;
    rdy_force_val = 1'b0;
    dout_pe_rdy   = 1'b0;
    repeat (4) tick();
    tick();
    rdy_force_en = 1'b0;
    dout_pe_rdy  = 1'b1;
    wait_done(2, 5, 1'b1);
    repeat (2) tick();

    // Abort in the SHIFT phase of pass 1, then a clean job.
    start_job(3);
    wait_tok(PH_SHIFT, -1, 1, -1);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (DMEM_LAT + 3) tick();
    check("busy_after_abort", busy, 1'b0);
    start_job(2);
    wait_done(2, 0, 1'b1);
    repeat (2) tick();

    // Reset in the middle of COMPUTE.
    start_job(2);
    wait_tok(PH_CMPT, 20, 0, -1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("iter_after_rst", iter_idx, 0);

    // abort together with din_pe_v in IDLE keeps the block idle.
    iter_num = ITER_W'(3);
    din_pe_v = 1'b1;
    abort    = 1'b1;
    tick();
    din_pe_v = 1'b0;
    abort    = 1'b0;
    repeat (3) tick();
    check("busy_abort_idle", busy, 1'b0);

    // Randomised jobs, alternating continuous and random ready.
    for (int j = 0; j < 6; j++) begin
      int n;
      n = $urandom_range(0, 4);
      rdy_rand = j[0];
      start_job(n);
      wait_done(n, 0, !rdy_rand);
      repeat ($urandom_range(0, 3)) tick();
    end
    rdy_rand = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
